oam_dma: RTL and testbench
==========================

Name: oam_dma

Overview:
- Sprite DMA engine on the CPU side of the PPU register interface; implements the $4014 OAM DMA port.
- Snoops CPU writes to DMA_REG_ADDR, halts the CPU, and copies XFER_LEN bytes from CPU page {data,8'h00} to OAMDATA_ADDR ($2004), one byte per GET/PUT cycle pair.
- Its bus outputs are muxed ahead of the existing PPU chip-select decode (addr[15:13]==1), so DMA writes reach the PPU unchanged.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers DMA.
- OAMDATA_ADDR, 16'h2004, destination address of every PUT cycle.
- XFER_LEN, 256, bytes per transfer; 1..256.

Ports:
- clk  in  1  CPU clock; one cycle = one CPU bus cycle.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_addr  in  16  CPU address, snooped.
- cpu_rw  in  1  CPU read/write; 1=read.
- cpu_data_o  in  8  CPU write data, snooped.
- mem_data_i  in  8  bus read data; synchronous memory, valid the cycle after the address.
- cpu_halt  out  1  stalls the CPU (RDY low) while 1.
- bus_sel  out  1  1 = system bus is driven by the dma_* outputs.
- dma_addr  out  16  DMA bus address.
- dma_rw  out  1  DMA read/write; 1=read.
- dma_data_o  out  8  DMA write data.
- dma_active  out  1  1 from the first HALT cycle through the final PUT cycle.

Behaviour:
- Reset (async assert, sync release): state=IDLE, cpu_halt=0, bus_sel=0, dma_active=0, dma_addr=0, dma_rw=1, dma_data_o=0, page=0, count=0, cyc_odd=0.
- cyc_odd toggles every clk; the first cycle after reset release is even (cyc_odd=0).
- Trigger: in IDLE, a cycle with cpu_addr==DMA_REG_ADDR and cpu_rw==0 (cycle W) latches page<=cpu_data_o[7:0] and count<=0 at the closing edge; next state is HALT. The write itself completes normally (no side effects elsewhere).
- Trigger is ignored outside IDLE; the CPU is halted then, so none can occur.
- States and per-cycle outputs:
  - IDLE: cpu_halt=0, bus_sel=0, dma_active=0.
  - HALT: 1 dummy cycle. cpu_halt=1, bus_sel=1, dma_active=1, dma_rw=1, dma_addr={page,8'h00}. Exit: if cyc_odd==1 -> GET, else -> ALIGN.
  - ALIGN: 1 dummy cycle, outputs as HALT. Exit -> GET.
  - GET: always on an even cycle. dma_rw=1, dma_addr={page,count}. Exit -> PUT.
  - PUT: dma_rw=0, dma_addr=OAMDATA_ADDR, dma_data_o=mem_data_i (combinational pass-through of the byte returned for the preceding GET).
    - If count==XFER_LEN-1: -> IDLE, count<=0.
    - Else: count<=count+1, -> GET.
- dma_data_o holds its last value outside PUT.
- cpu_halt, bus_sel, dma_active: registered state decodes, asserted together for the whole of HALT..last PUT.
- Length: cycles W+1 through the final PUT = 1 + ALIGN(0/1) + 2*XFER_LEN = 513 or 514 for 256 bytes. The CPU resumes on the cycle after the final PUT.
- count is 8 bits. With XFER_LEN=256 the source address stays within the page: {page,8'hFF} is the last read; there is no carry into page.
- page=8'h20..8'h3F (PPU register space) is legal: source reads go to the mirrored PPU registers with no special handling.
- Reset mid-transfer: immediate return to IDLE, all outputs to reset values. A partial OAM load is acceptable; no resume.

Test Plan:
- Reset, then CPU writes 8'h02 to $4014 with HALT landing on an odd cycle -> cpu_halt high for exactly 513 cycles; GET addrs $0200..$02FF in order; 256 PUTs to $2004.
- Same write shifted one cycle so HALT is even -> exactly one ALIGN cycle, 514 halted cycles, every GET on cyc_odd==0.
- Source page preloaded with byte i = i^8'hA5 -> PUT k carries dma_data_o = k^8'hA5; PPU OAM readback via $2004 matches all 256 entries.
- CPU read of $4014 and write to $4015 -> no trigger; cpu_halt stays 0.
- rst_n pulled low at PUT #100 -> all outputs return to reset values asynchronously; new $4014 write of 8'h03 after release performs a full clean 513/514-cycle transfer from $0300.
- XFER_LEN=4, page 8'h07 -> GETs $0700..$0703, 4 PUTs, cpu_halt drops after 9 or 10 cycles.

Source files
------------

// File: rtl/oam_dma_if.sv
// -----------------------------------------------------------------------------
// oam_dma_if
// Bus bundle between the OAM DMA engine and the system bus.
//
// Signals
//   cpu_addr    [15:0]  CPU address, snooped by the DMA engine
//   cpu_rw              CPU read/write, 1 = read
//   cpu_data_o  [7:0]   CPU write data, snooped
//   mem_data_i  [7:0]   bus read data, valid the cycle after the address
//   cpu_halt            stalls the CPU (RDY low) while 1
//   bus_sel             1 = system bus is driven by the dma_* signals
//   dma_addr    [15:0]  DMA bus address
//   dma_rw              DMA read/write, 1 = read
//   dma_data_o  [7:0]   DMA write data
//   dma_active          1 from the first HALT cycle through the final PUT
//
// Modports
//   master : the DMA engine
//   slave  : the system side (CPU snoop source, memory, bus mux)
// -----------------------------------------------------------------------------
interface oam_dma_if;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic [7:0]  cpu_data_o;
    logic [7:0]  mem_data_i;
    logic        cpu_halt;
    logic        bus_sel;
    logic [15:0] dma_addr;
    logic        dma_rw;
    logic [7:0]  dma_data_o;
    logic        dma_active;

    modport master (
        input  cpu_addr, cpu_rw, cpu_data_o, mem_data_i,
        output cpu_halt, bus_sel, dma_addr, dma_rw, dma_data_o, dma_active
    );

    modport slave (
        output cpu_addr, cpu_rw, cpu_data_o, mem_data_i,
        input  cpu_halt, bus_sel, dma_addr, dma_rw, dma_data_o, dma_active
    );
endinterface

// File: rtl/oam_dma.sv
// -----------------------------------------------------------------------------
// oam_dma
// Sprite DMA engine for the $4014 OAM DMA port. A CPU write to DMA_REG_ADDR
// halts the CPU and copies XFER_LEN bytes from page {data,8'h00} to
// OAMDATA_ADDR, one byte per GET/PUT cycle pair. GETs always fall on even
// cycles, so one ALIGN dummy cycle is inserted when HALT lands on an even
// cycle.
//
// Ports
//   clk     CPU clock, one cycle = one CPU bus cycle
//   rst_n   asynchronous active-low reset
//   bus_if  oam_dma_if.master bundle (CPU snoop inputs, memory read data,
//           halt / bus-select / DMA bus outputs)
// -----------------------------------------------------------------------------
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter logic [15:0] OAMDATA_ADDR = 16'h2004,
    parameter int          XFER_LEN     = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    oam_dma_if.master    bus_if
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HALT  = 3'd1;
    localparam logic [2:0] S_ALIGN = 3'd2;
    localparam logic [2:0] S_GET   = 3'd3;
    localparam logic [2:0] S_PUT   = 3'd4;

    // Index of the final byte; 8 bits wide so a 256-byte transfer ends at
    // {page,8'hFF} without ever carrying into the page.
    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] page_q,  page_d;
    logic [7:0] count_q, count_d;
    logic [7:0] data_q,  data_d;
    logic       cyc_odd_q;
    logic       busy;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        count_d = count_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (bus_if.cpu_addr == DMA_REG_ADDR && !bus_if.cpu_rw) begin
                    page_d  = bus_if.cpu_data_o;
                    count_d = 8'h00;
                    state_d = S_HALT;
                end
            end
            // An odd HALT means the next cycle is already even: go straight
            // to GET; otherwise burn one ALIGN cycle.
            S_HALT:  state_d = cyc_odd_q ? S_GET : S_ALIGN;
            S_ALIGN: state_d = S_GET;
            S_GET:   state_d = S_PUT;
            S_PUT: begin
                // Remember the byte so dma_data_o holds it after the PUT
                data_d = bus_if.mem_data_i;
                if (count_q == LAST_IDX) begin
                    count_d = 8'h00;
                    state_d = S_IDLE;
                end else begin
                    count_d = count_q + 8'h01;
                    state_d = S_GET;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            page_q    <= 8'h00;
            count_q   <= 8'h00;
            data_q    <= 8'h00;
            cyc_odd_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            page_q    <= page_d;
            count_q   <= count_d;
            data_q    <= data_d;
            cyc_odd_q <= ~cyc_odd_q;
        end
    end

    // Outputs are pure decodes of the registered state
    assign busy              = (state_q != S_IDLE);
    assign bus_if.cpu_halt   = busy;
    assign bus_if.bus_sel    = busy;
    assign bus_if.dma_active = busy;
    assign bus_if.dma_rw     = (state_q != S_PUT);

    // PUT passes the byte fetched by the preceding GET straight through
    assign bus_if.dma_data_o = (state_q == S_PUT) ? bus_if.mem_data_i : data_q;

    always_comb begin
        case (state_q)
            S_HALT, S_ALIGN: bus_if.dma_addr = {page_q, 8'h00};
            S_GET:           bus_if.dma_addr = {page_q, count_q};
            S_PUT:           bus_if.dma_addr = OAMDATA_ADDR;
            default:         bus_if.dma_addr = 16'h0000;
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// -----------------------------------------------------------------------------
// tb_oam_dma
// Testbench for oam_dma: a 256-byte instance and a 4-byte instance sharing
// clock, reset and a 64 KiB source memory. Bus traffic of each halted cycle is
// recorded and compared against a cycle list built from the transfer rules.
// -----------------------------------------------------------------------------
module tb_oam_dma;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    oam_dma_if bus();
    oam_dma_if bus4();

    oam_dma dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus)
    );

    oam_dma #(.XFER_LEN(4)) dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus4)
    );

    // ---------------- system bus / memory model ----------------
    logic [7:0]  mem [0:65535];
    logic [7:0]  oam [0:255];
    logic [7:0]  oam_ptr = 8'h00;
    logic [15:0] a_s, a4_s;
    logic        rw_s;
    logic [7:0]  d_s;

    // Bus is sampled mid-cycle so the memory model never races the DUT edge
    always @(negedge clk) begin
        a_s  = bus.bus_sel ? bus.dma_addr   : bus.cpu_addr;
        rw_s = bus.bus_sel ? bus.dma_rw     : bus.cpu_rw;
        d_s  = bus.bus_sel ? bus.dma_data_o : bus.cpu_data_o;
        a4_s = bus4.bus_sel ? bus4.dma_addr : bus4.cpu_addr;
    end

    always @(posedge clk) begin
        bus.mem_data_i  <= mem[a_s];
        bus4.mem_data_i <= mem[a4_s];
        if (!rw_s && a_s == 16'h2004) begin
            oam[oam_ptr] <= d_s;
            oam_ptr      <= oam_ptr + 8'h01;
        end
    end

    // ---------------- bookkeeping ----------------
    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int sync_err;
    bit timed_out;

    bit          rec_rw[$];
    logic [15:0] rec_addr[$];
    logic [7:0]  rec_data[$];
    bit          rec_par[$];

    bit          exp_rw[$];
    logic [15:0] exp_addr[$];
    logic [7:0]  exp_data[$];
    bit          exp_get[$];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    // One CPU bus cycle on either instance, then back to an idle read
    task automatic cpu_cycle(input bit use4, input logic [15:0] a, input bit rw, input logic [7:0] d);
        if (use4) begin
            bus4.cpu_addr = a; bus4.cpu_rw = rw; bus4.cpu_data_o = d;
        end else begin
            bus.cpu_addr = a; bus.cpu_rw = rw; bus.cpu_data_o = d;
        end
        tick();
        if (use4) begin
            bus4.cpu_addr = 16'h0000; bus4.cpu_rw = 1'b1; bus4.cpu_data_o = 8'h00;
        end else begin
            bus.cpu_addr = 16'h0000; bus.cpu_rw = 1'b1; bus.cpu_data_o = 8'h00;
        end
    endtask

    task automatic fill_page(input logic [7:0] pg, input bit pattern);
        for (int i = 0; i < 256; i++)
            mem[{pg, 8'(i)}] = pattern ? (8'(i) ^ 8'hA5) : 8'($urandom);
    endtask

    // Records every halted cycle until the CPU is released (bounded)
    task automatic capture(input bit use4);
        int n;
        logic h, s, a;
        n = 0;
        rec_rw.delete(); rec_addr.delete(); rec_data.delete(); rec_par.delete();
        sync_err  = 0;
        timed_out = 0;
        h = use4 ? bus4.cpu_halt : bus.cpu_halt;
        while (h === 1'b1 && n < 700) begin
            s = use4 ? bus4.bus_sel    : bus.bus_sel;
            a = use4 ? bus4.dma_active : bus.dma_active;
            if (s !== 1'b1 || a !== 1'b1) sync_err++;
            rec_rw.push_back(use4 ? bus4.dma_rw : bus.dma_rw);
            rec_addr.push_back(use4 ? bus4.dma_addr : bus.dma_addr);
            rec_data.push_back(use4 ? bus4.dma_data_o : bus.dma_data_o);
            rec_par.push_back(bit'(cyc % 2));
            tick();
            n++;
            h = use4 ? bus4.cpu_halt : bus.cpu_halt;
        end
        if (n >= 700) timed_out = 1;
    endtask

    // Reference cycle list: dummy read(s) at the page base, then n
    // read/write pairs, every read on an even cycle.
    task automatic model_xfer(input logic [7:0] pg, input int halt_cyc, input int n);
        exp_rw.delete(); exp_addr.delete(); exp_data.delete(); exp_get.delete();
        for (int i = 0; i < ((halt_cyc % 2 == 0) ? 2 : 1); i++) begin
            exp_rw.push_back(1'b1); exp_addr.push_back({pg, 8'h00});
            exp_data.push_back(8'h00); exp_get.push_back(1'b0);
        end
        for (int k = 0; k < n; k++) begin
            exp_rw.push_back(1'b1); exp_addr.push_back({pg, 8'(k)});
            exp_data.push_back(8'h00); exp_get.push_back(1'b1);
            exp_rw.push_back(1'b0); exp_addr.push_back(16'h2004);
            exp_data.push_back(mem[{pg, 8'(k)}]); exp_get.push_back(1'b0);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        vectors++;
        if ({bus.cpu_halt, bus.bus_sel, bus.dma_active, bus.dma_rw} !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_ctrl: got halt/sel/act/rw=%b, want 0001",
                     {bus.cpu_halt, bus.bus_sel, bus.dma_active, bus.dma_rw});
        end
        vectors++;
        if ({bus.dma_addr, bus.dma_data_o} !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_bus: got addr=%h data=%h, want 0000/00", bus.dma_addr, bus.dma_data_o);
        end
        vectors++;
        if ({bus4.cpu_halt, bus4.dma_rw, bus4.dma_addr, bus4.dma_data_o} !== {1'b0, 1'b1, 24'h0}) begin
            miscompares++;
            $display("FAIL reset_short: got halt=%b rw=%b addr=%h data=%h, want 0 1 0000 00",
                     bus4.cpu_halt, bus4.dma_rw, bus4.dma_addr, bus4.dma_data_o);
        end
        $display("test_reset done");
    endtask

    task automatic test_odd_halt();
        int hc;
        fill_page(8'h02, 1'b0);
        if (cyc % 2 == 1) tick();          // write on even -> HALT odd
        cpu_cycle(1'b0, 16'h4014, 1'b0, 8'h02);
        hc = cyc;
        model_xfer(8'h02, hc, 256);
        capture(1'b0);
        vectors++;
        if (rec_rw.size() != 513 || timed_out) begin
            miscompares++;
            $display("FAIL odd_len: got %0d halted cycles (timeout=%0d), want 513", rec_rw.size(), timed_out);
        end
        vectors++;
        if (sync_err != 0) begin
            miscompares++;
            $display("FAIL odd_sync: got %0d cycles with sel/active low, want 0", sync_err);
        end
        for (int i = 0; i < rec_rw.size() && i < exp_rw.size(); i++) begin
            vectors++;
            if (rec_rw[i] !== exp_rw[i] || rec_addr[i] !== exp_addr[i] ||
                (!exp_rw[i] && rec_data[i] !== exp_data[i]) || (exp_get[i] && rec_par[i] !== 1'b0)) begin
                miscompares++;
                $display("FAIL odd_seq[%0d]: got rw=%b addr=%h data=%h odd=%b, want rw=%b addr=%h data=%h",
                         i, rec_rw[i], rec_addr[i], rec_data[i], rec_par[i], exp_rw[i], exp_addr[i], exp_data[i]);
            end
        end
        vectors++;
        if (bus.cpu_halt !== 1'b0 || bus.dma_data_o !== mem[16'h02FF]) begin
            miscompares++;
            $display("FAIL odd_after: got halt=%b data=%h, want 0 %h", bus.cpu_halt, bus.dma_data_o, mem[16'h02FF]);
        end
        $display("test_odd_halt: HALT at cycle %0d, %0d halted cycles", hc, rec_rw.size());
    endtask

    task automatic test_even_halt();
        int hc;
        logic [7:0] pg;
        pg = 8'($urandom_range(0, 255));
        fill_page(pg, 1'b0);
        if (cyc % 2 == 0) tick();          // write on odd -> HALT even
        cpu_cycle(1'b0, 16'h4014, 1'b0, pg);
        hc = cyc;
        model_xfer(pg, hc, 256);
        capture(1'b0);
        vectors++;
        if (rec_rw.size() != 514 || timed_out) begin
            miscompares++;
            $display("FAIL even_len: got %0d halted cycles (timeout=%0d), want 514", rec_rw.size(), timed_out);
        end
        for (int i = 0; i < rec_rw.size() && i < exp_rw.size(); i++) begin
            vectors++;
            if (rec_rw[i] !== exp_rw[i] || rec_addr[i] !== exp_addr[i] ||
                (!exp_rw[i] && rec_data[i] !== exp_data[i]) || (exp_get[i] && rec_par[i] !== 1'b0)) begin
                miscompares++;
                $display("FAIL even_seq[%0d]: got rw=%b addr=%h data=%h odd=%b, want rw=%b addr=%h data=%h",
                         i, rec_rw[i], rec_addr[i], rec_data[i], rec_par[i], exp_rw[i], exp_addr[i], exp_data[i]);
            end
        end
        $display("test_even_halt: page %h HALT at cycle %0d, %0d halted cycles", pg, hc, rec_rw.size());
    endtask

    task automatic test_data_oam();
        int hc;
        logic [7:0] start;
        fill_page(8'h02, 1'b1);
        start = oam_ptr;
        cpu_cycle(1'b0, 16'h4014, 1'b0, 8'h02);
        hc = cyc;
        model_xfer(8'h02, hc, 256);
        capture(1'b0);
        vectors++;
        if (rec_rw.size() != exp_rw.size() || timed_out) begin
            miscompares++;
            $display("FAIL data_len: got %0d halted cycles, want %0d", rec_rw.size(), exp_rw.size());
        end
        for (int i = 0; i < rec_rw.size() && i < exp_rw.size(); i++) begin
            if (!exp_rw[i]) begin
                vectors++;
                if (rec_rw[i] !== 1'b0 || rec_data[i] !== exp_data[i]) begin
                    miscompares++;
                    $display("FAIL data_put[%0d]: got rw=%b data=%h, want rw=0 data=%h",
                             i, rec_rw[i], rec_data[i], exp_data[i]);
                end
            end
        end
        for (int k = 0; k < 256; k++) begin
            vectors++;
            if (oam[8'(start + 8'(k))] !== (8'(k) ^ 8'hA5)) begin
                miscompares++;
                $display("FAIL oam[%0d]: got %h, want %h", k, oam[8'(start + 8'(k))], 8'(k) ^ 8'hA5);
            end
        end
        $display("test_data_oam: HALT at cycle %0d, OAM readback of 256 entries", hc);
    endtask

    task automatic test_no_trigger();
        cpu_cycle(1'b0, 16'h4014, 1'b1, 8'h02);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (bus.cpu_halt !== 1'b0 || bus.dma_active !== 1'b0) begin
                miscompares++;
                $display("FAIL notrig_read: got halt=%b active=%b, want 0 0", bus.cpu_halt, bus.dma_active);
            end
            tick();
        end
        cpu_cycle(1'b0, 16'h4015, 1'b0, 8'h02);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (bus.cpu_halt !== 1'b0 || bus.dma_active !== 1'b0) begin
                miscompares++;
                $display("FAIL notrig_4015: got halt=%b active=%b, want 0 0", bus.cpu_halt, bus.dma_active);
            end
            tick();
        end
        $display("test_no_trigger: read $4014 and write $4015 ignored");
    endtask

    task automatic test_reset_mid();
        int puts, n, hc;
        logic [7:0] pg;
        pg = 8'($urandom_range(0, 255));
        fill_page(pg, 1'b0);
        cpu_cycle(1'b0, 16'h4014, 1'b0, pg);
        puts = 0;
        n    = 0;
        while (n < 400) begin
            if (bus.cpu_halt === 1'b1 && bus.dma_rw === 1'b0) puts++;
            if (puts == 100) break;
            tick();
            n++;
        end
        vectors++;
        if (puts != 100) begin
            miscompares++;
            $display("FAIL mid_puts: got %0d PUTs within bound, want 100", puts);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.cpu_halt, bus.bus_sel, bus.dma_active, bus.dma_rw} !== 4'b0001) begin
            miscompares++;
            $display("FAIL mid_rst_ctrl: got halt/sel/act/rw=%b, want 0001",
                     {bus.cpu_halt, bus.bus_sel, bus.dma_active, bus.dma_rw});
        end
        vectors++;
        if ({bus.dma_addr, bus.dma_data_o} !== 24'h0) begin
            miscompares++;
            $display("FAIL mid_rst_bus: got addr=%h data=%h, want 0000/00", bus.dma_addr, bus.dma_data_o);
        end
        tick();
        tick();
        rst_n = 1'b1;
        cyc   = 0;
        fill_page(8'h03, 1'b0);
        if ($urandom_range(0, 1) == 1) tick();
        cpu_cycle(1'b0, 16'h4014, 1'b0, 8'h03);
        hc = cyc;
        model_xfer(8'h03, hc, 256);
        capture(1'b0);
        vectors++;
        if (rec_rw.size() != ((hc % 2 == 0) ? 514 : 513) || timed_out) begin
            miscompares++;
            $display("FAIL mid_len: got %0d halted cycles, want %0d", rec_rw.size(), (hc % 2 == 0) ? 514 : 513);
        end
        for (int i = 0; i < rec_rw.size() && i < exp_rw.size(); i++) begin
            vectors++;
            if (rec_rw[i] !== exp_rw[i] || rec_addr[i] !== exp_addr[i] ||
                (!exp_rw[i] && rec_data[i] !== exp_data[i]) || (exp_get[i] && rec_par[i] !== 1'b0)) begin
                miscompares++;
                $display("FAIL mid_seq[%0d]: got rw=%b addr=%h data=%h odd=%b, want rw=%b addr=%h data=%h",
                         i, rec_rw[i], rec_addr[i], rec_data[i], rec_par[i], exp_rw[i], exp_addr[i], exp_data[i]);
            end
        end
        $display("test_reset_mid: reset at PUT 100, restart page 03 HALT at cycle %0d, %0d halted cycles",
                 hc, rec_rw.size());
    endtask

    task automatic test_short_len();
        int hc;
        for (int rep = 0; rep < 2; rep++) begin
            fill_page(8'h07, 1'b0);
            if ((cyc % 2) != rep) tick();   // covers both HALT parities
            cpu_cycle(1'b1, 16'h4014, 1'b0, 8'h07);
            hc = cyc;
            model_xfer(8'h07, hc, 4);
            capture(1'b1);
            vectors++;
            if (rec_rw.size() != ((hc % 2 == 0) ? 10 : 9) || timed_out) begin
                miscompares++;
                $display("FAIL short_len: got %0d halted cycles, want %0d", rec_rw.size(), (hc % 2 == 0) ? 10 : 9);
            end
            vectors++;
            if (sync_err != 0) begin
                miscompares++;
                $display("FAIL short_sync: got %0d cycles with sel/active low, want 0", sync_err);
            end
            for (int i = 0; i < rec_rw.size() && i < exp_rw.size(); i++) begin
                vectors++;
                if (rec_rw[i] !== exp_rw[i] || rec_addr[i] !== exp_addr[i] ||
                    (!exp_rw[i] && rec_data[i] !== exp_data[i]) || (exp_get[i] && rec_par[i] !== 1'b0)) begin
                    miscompares++;
                    $display("FAIL short_seq[%0d]: got rw=%b addr=%h data=%h odd=%b, want rw=%b addr=%h data=%h",
                             i, rec_rw[i], rec_addr[i], rec_data[i], rec_par[i], exp_rw[i], exp_addr[i], exp_data[i]);
                end
            end
            $display("test_short_len: HALT at cycle %0d, %0d halted cycles", hc, rec_rw.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.cpu_addr  = 16'h0000; bus.cpu_rw  = 1'b1; bus.cpu_data_o  = 8'h00;
        bus4.cpu_addr = 16'h0000; bus4.cpu_rw = 1'b1; bus4.cpu_data_o = 8'h00;
        test_reset();
        test_odd_halt();
        test_even_halt();
        test_data_oam();
        test_no_trigger();
        test_reset_mid();
        test_short_len();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
